rst_seq_wdog: RTL and testbench
===============================

# rst_seq_wdog

Parametrised reset sequencer and run-time watchdog for the course test harnesses and multi-unit designs. It takes one clock and an asynchronous active-high reset. It drives NCH per-channel reset outputs, releasing them synchronously in a staggered order. It then counts run cycles, halts on an error input or a cycle-limit timeout, and captures the cycle of the first error, so benches can stop cleanly.

## Interface
Parameters:
- NCH, 4 — number of reset output channels (1..16)
- RST_CYCLES, 2 — posedges rst_out[0] stays asserted after rst deasserts (≥1)
- STAGGER, 1 — posedges between consecutive channel releases (0 = all release together)
- CW, 32 — cycle counter width
- MAX_CYCLES, 100000 — run-cycle limit; 0 disables the watchdog

Ports:
- clk  in  1  — single clock
- rst  in  1  — reset; asynchronous, active-high
- err  in  1  — error indication from the design under test, sampled on posedge clk
- rst_out  out  NCH  — per-channel active-high resets, deasserted synchronously to clk
- cycle_count  out  CW  — run cycles elapsed
- running  out  1  — state is RUN
- halted  out  1  — state is HALT_ERR or HALT_TO
- timeout  out  1  — sticky; watchdog limit reached
- err_flag  out  1  — sticky; err seen during RUN
- err_cycle  out  CW  — cycle_count value at the first err

## Operation
- States: ASSERT → RELEASE → RUN → {HALT_ERR | HALT_TO}. HALT states are terminal; they exit only via rst.
- While rst=1 (asynchronous):
  - state=ASSERT
  - rst_out all ones
  - cycle_count, err_cycle = 0
  - running, halted, timeout, err_flag = 0
- Posedge numbering: the first posedge after rst falls is edge 1.
- Channel release: rst_out[k] goes 0 at edge RST_CYCLES + k·STAGGER. The state is RELEASE from edge RST_CYCLES until the last channel releases.
- The state enters RUN on the edge rst_out[NCH-1] releases; this is the same edge as rst_out[0] when STAGGER=0 or NCH=1.
- In RUN, cycle_count increments by 1 every posedge. It saturates at 2^CW−1 and never wraps.
- Watchdog: at a posedge in RUN where MAX_CYCLES≠0 and cycle_count == MAX_CYCLES−1:
  - cycle_count becomes MAX_CYCLES
  - timeout=1
  - state goes to HALT_TO
- Error: err=1 at a posedge in RUN:
  - err_flag=1
  - err_cycle = pre-increment cycle_count
  - halt behaviour per Configuration
- err during ASSERT/RELEASE/HALT_* is ignored. Only the first err in RUN updates err_cycle.
- Simultaneous err and watchdog on the same edge: err takes priority. With halting enabled, the state goes to HALT_ERR and timeout stays 0.
- In HALT states:
  - cycle_count frozen
  - rst_out stays all zeros
  - halted=1
  - running=0
- rst asserted mid-operation, in any state: immediate asynchronous return to reset values; the sequence restarts from edge 1 after release.

## Timing
- All outputs are registered; there is no combinational path from err to any output.
- rst_out assertion is asynchronous; deassertion is registered on clk.
- running rises on the same edge rst_out[NCH-1] falls.
- err_flag, err_cycle and the halt state update on the edge that samples err, giving 1-cycle latency.
- Default config: rst_out[0..3] release at edges 2,3,4,5. running=1 after edge 5. timeout=1 after edge 5+100000.

## Configuration
- RST_SEQ_ERR_HALT_EN defined: err in RUN moves the state to HALT_ERR and freezes cycle_count.
- RST_SEQ_ERR_HALT_EN undefined: err in RUN only sets err_flag/err_cycle. The state remains RUN, counting continues, and the watchdog still applies.
- No other behaviour depends on the macro.

## Test plan
- Reset release, defaults: hold rst 3 cycles, release, err=0 → rst_out 4'b1111, then 1110 after edge 2, 1100 after edge 3, 1000 after edge 4, 0000 after edge 5; running=1 after edge 5.
- STAGGER=0, NCH=2, RST_CYCLES=3 → rst_out 2'b11 to 2'b00 on edge 3; cycle_count=1 after edge 4.
- Watchdog, MAX_CYCLES=10 → timeout=1, halted=1, cycle_count=10 frozen for ≥20 further cycles.
- Error with RST_SEQ_ERR_HALT_EN: pulse err 1 cycle when cycle_count=7 → err_flag=1, err_cycle=7, halted=1, cycle_count stays 7. Without the macro: err_cycle=7, counting continues; a second err at 12 leaves err_cycle=7.
- Collision, MAX_CYCLES=10, macro defined: err=1 when cycle_count=9 → HALT_ERR, err_cycle=9, timeout=0.
- Mid-run reset: assert rst asynchronously (off clock edge) at cycle_count=50 → rst_out=1111 and all other outputs 0 immediately; after release, sequence repeats exactly as in the first scenario.

Source files
------------

// File: rtl/rst_seq_wdog.sv
// Staggered per-channel reset sequencer followed by a run-cycle counter and watchdog.
// Optional macro RST_SEQ_ERR_HALT_EN: an err seen while running halts the sequencer.
module rst_seq_wdog #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned STAGGER    = 1,
    parameter int unsigned CW         = 32,
    parameter int unsigned MAX_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           err,
    output logic [NCH-1:0] rst_out,
    output logic [CW-1:0]  cycle_count,
    output logic           running,
    output logic           halted,
    output logic           timeout,
    output logic           err_flag,
    output logic [CW-1:0]  err_cycle,
    output logic [2:0]     state_dbg
);

    // Edge on which the last channel releases; the edge counter never needs to exceed it.
    localparam int unsigned   LAST_EDGE = RST_CYCLES + (NCH - 1) * STAGGER;
    localparam int unsigned   RW        = $clog2(LAST_EDGE + 2);
    localparam logic [RW-1:0] FIRST_E   = RW'(RST_CYCLES);
    localparam logic [RW-1:0] LAST_E    = RW'(LAST_EDGE);
    localparam logic [RW-1:0] ONE_E     = RW'(1);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam bit            WD_EN     = (MAX_CYCLES != 0);
    localparam logic [CW-1:0] WD_LAST   = WD_EN ? CW'(MAX_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_ASSERT   = 3'd0,
        S_RELEASE  = 3'd1,
        S_RUN      = 3'd2,
        S_HALT_ERR = 3'd3,
        S_HALT_TO  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   edge_q, edge_d;
    logic [RW-1:0]   edge_num;
    logic [NCH-1:0]  rst_out_q, rst_out_d;
    logic [CW-1:0]   count_q, count_d;
    logic            timeout_q, timeout_d;
    logic            err_flag_q, err_flag_d;
    logic [CW-1:0]   err_cycle_q, err_cycle_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ASSERT;
            edge_q      <= '0;
            rst_out_q   <= '1;
            count_q     <= '0;
            timeout_q   <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cycle_q <= '0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            rst_out_q   <= rst_out_d;
            count_q     <= count_d;
            timeout_q   <= timeout_d;
            err_flag_q  <= err_flag_d;
            err_cycle_q <= err_cycle_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        edge_d      = edge_q;
        rst_out_d   = rst_out_q;
        count_d     = count_q;
        timeout_d   = timeout_q;
        err_flag_d  = err_flag_q;
        err_cycle_d = err_cycle_q;
        // edge_num is the 1-based number of the posedge being evaluated.
        edge_num    = edge_q + ONE_E;

        case (state_q)
            S_ASSERT, S_RELEASE: begin
                edge_d = edge_num;
                for (int unsigned k = 0; k < NCH; k++) begin
                    rst_out_d[k] = !(edge_num >= RW'(RST_CYCLES + k * STAGGER));
                end
                if (edge_num >= LAST_E) begin
                    state_d = S_RUN;
                end else if (edge_num >= FIRST_E) begin
                    state_d = S_RELEASE;
                end
            end
            S_RUN: begin
                if (count_q != '1) begin
                    count_d = count_q + ONE_C;
                end
                if (WD_EN && (count_q == WD_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT_TO;
                end
                // err is evaluated last so it overrides a coincident watchdog halt.
                if (err) begin
                    if (!err_flag_q) begin
                        err_cycle_d = count_q;
                    end
                    err_flag_d = 1'b1;
`ifdef RST_SEQ_ERR_HALT_EN
                    state_d    = S_HALT_ERR;
                    count_d    = count_q;
                    timeout_d  = timeout_q;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    assign rst_out     = rst_out_q;
    assign cycle_count = count_q;
    assign running     = (state_q == S_RUN);
    assign halted      = (state_q == S_HALT_ERR) || (state_q == S_HALT_TO);
    assign timeout     = timeout_q;
    assign err_flag    = err_flag_q;
    assign err_cycle   = err_cycle_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_rst_seq_wdog.sv
// Directed bench for rst_seq_wdog: several parameterisations share clk/rst, each with its own err.
// Expectations follow RST_SEQ_ERR_HALT_EN when it is defined for the build.
module tb_rst_seq_wdog;

`ifdef RST_SEQ_ERR_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic err_def, err_s0, err_wd, err_col, err_sat;
    int   n_chk = 0;
    int   n_err = 0;
    int   edge_n = 0;
    logic [3:0] exp_q[$];

    logic [3:0]  d_rst_out;   logic [31:0] d_cnt;  logic d_run, d_halt, d_to, d_ef; logic [31:0] d_ec;  logic [2:0] d_st;
    logic [1:0]  s_rst_out;   logic [31:0] s_cnt;  logic s_run, s_halt, s_to, s_ef; logic [31:0] s_ec;  logic [2:0] s_st;
    logic [3:0]  w_rst_out;   logic [31:0] w_cnt;  logic w_run, w_halt, w_to, w_ef; logic [31:0] w_ec;  logic [2:0] w_st;
    logic [3:0]  c_rst_out;   logic [31:0] c_cnt;  logic c_run, c_halt, c_to, c_ef; logic [31:0] c_ec;  logic [2:0] c_st;
    logic [0:0]  t_rst_out;   logic [3:0]  t_cnt;  logic t_run, t_halt, t_to, t_ef; logic [3:0]  t_ec;  logic [2:0] t_st;

    always #5 clk = ~clk;

    rst_seq_wdog u_def (
        .clk(clk), .rst(rst), .err(err_def), .rst_out(d_rst_out), .cycle_count(d_cnt),
        .running(d_run), .halted(d_halt), .timeout(d_to), .err_flag(d_ef), .err_cycle(d_ec),
        .state_dbg(d_st)
    );

    rst_seq_wdog #(.NCH(2), .RST_CYCLES(3), .STAGGER(0)) u_s0 (
        .clk(clk), .rst(rst), .err(err_s0), .rst_out(s_rst_out), .cycle_count(s_cnt),
        .running(s_run), .halted(s_halt), .timeout(s_to), .err_flag(s_ef), .err_cycle(s_ec),
        .state_dbg(s_st)
    );

    rst_seq_wdog #(.MAX_CYCLES(10)) u_wd (
        .clk(clk), .rst(rst), .err(err_wd), .rst_out(w_rst_out), .cycle_count(w_cnt),
        .running(w_run), .halted(w_halt), .timeout(w_to), .err_flag(w_ef), .err_cycle(w_ec),
        .state_dbg(w_st)
    );

    rst_seq_wdog #(.MAX_CYCLES(10)) u_col (
        .clk(clk), .rst(rst), .err(err_col), .rst_out(c_rst_out), .cycle_count(c_cnt),
        .running(c_run), .halted(c_halt), .timeout(c_to), .err_flag(c_ef), .err_cycle(c_ec),
        .state_dbg(c_st)
    );

    rst_seq_wdog #(.NCH(1), .RST_CYCLES(1), .CW(4), .MAX_CYCLES(0)) u_sat (
        .clk(clk), .rst(rst), .err(err_sat), .rst_out(t_rst_out), .cycle_count(t_cnt),
        .running(t_run), .halted(t_halt), .timeout(t_to), .err_flag(t_ef), .err_cycle(t_ec),
        .state_dbg(t_st)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) tick();
    endtask

    task automatic check_def_reset(input string tag);
        check({tag, "_rst_out"}, 32'(d_rst_out), 32'hf);
        check({tag, "_cnt"}, d_cnt, 32'd0);
        check({tag, "_running"}, 32'(d_run), 32'd0);
        check({tag, "_halted"}, 32'(d_halt), 32'd0);
        check({tag, "_timeout"}, 32'(d_to), 32'd0);
        check({tag, "_err_flag"}, 32'(d_ef), 32'd0);
        check({tag, "_err_cycle"}, d_ec, 32'd0);
    endtask

    // Release rst and walk edges 1..6; optionally hold err_def high while channels are releasing.
    task automatic run_release_seq(input bit err_in_release);
        rst = 1'b0;
        edge_n = 0;
        exp_q = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        if (err_in_release) err_def = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("def_rst_out", 32'(d_rst_out), 32'(exp_q.pop_front()));
            if (e == 1) check("sat_running_e1", 32'(t_run), 32'd1);
            if (e == 2) check("s0_rst_out_e2", 32'(s_rst_out), 32'h3);
            if (e == 3) begin
                check("s0_rst_out_e3", 32'(s_rst_out), 32'h0);
                check("s0_running_e3", 32'(s_run), 32'd1);
            end
            if (e == 4) begin
                check("s0_cnt_e4", s_cnt, 32'd1);
                check("def_running_e4", 32'(d_run), 32'd0);
                err_def = 1'b0;
            end
        end
        check("def_running_e5", 32'(d_run), 32'd1);
        check("def_cnt_e5", d_cnt, 32'd0);
        check("def_err_flag_e5", 32'(d_ef), 32'd0);
        tick();
        check("def_cnt_e6", d_cnt, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        err_def = 1'b0; err_s0 = 1'b0; err_wd = 1'b0; err_col = 1'b0; err_sat = 1'b0;
        repeat (3) tick();
        check_def_reset("rst0");
        run_release_seq(1'b0);

        run_to(12);
        check("def_cnt_e12", d_cnt, 32'd7);
        err_def = 1'b1;
        tick();
        err_def = 1'b0;
        check("def_err_flag", 32'(d_ef), 32'd1);
        check("def_err_cycle", d_ec, 32'd7);
        check("def_cnt_e13", d_cnt, HALT_EN ? 32'd7 : 32'd8);
        check("def_halted_e13", 32'(d_halt), HALT_EN ? 32'd1 : 32'd0);
        check("def_running_e13", 32'(d_run), HALT_EN ? 32'd0 : 32'd1);

        run_to(14);
        check("col_cnt_e14", c_cnt, 32'd9);
        check("wd_cnt_e14", w_cnt, 32'd9);
        err_col = 1'b1;
        tick();
        err_col = 1'b0;
        check("wd_timeout", 32'(w_to), 32'd1);
        check("wd_halted", 32'(w_halt), 32'd1);
        check("wd_cnt_e15", w_cnt, 32'd10);
        check("col_err_cycle", c_ec, 32'd9);
        check("col_err_flag", 32'(c_ef), 32'd1);
        check("col_halted", 32'(c_halt), 32'd1);
        check("col_timeout", 32'(c_to), HALT_EN ? 32'd0 : 32'd1);
        check("col_cnt", c_cnt, HALT_EN ? 32'd9 : 32'd10);
        check("col_state", 32'(c_st), HALT_EN ? 32'd3 : 32'd4);

        run_to(17);
        check("def_cnt_e17", d_cnt, HALT_EN ? 32'd7 : 32'd12);
        err_def = 1'b1;
        tick();
        err_def = 1'b0;
        check("def_err_cycle_2nd", d_ec, 32'd7);
        check("def_cnt_e18", d_cnt, HALT_EN ? 32'd7 : 32'd13);

        run_to(35);
        check("wd_cnt_frozen", w_cnt, 32'd10);
        check("wd_running_halt", 32'(w_run), 32'd0);
        check("wd_rst_out_halt", 32'(w_rst_out), 32'd0);
        check("col_cnt_frozen", c_cnt, HALT_EN ? 32'd9 : 32'd10);

        run_to(55);
        check("def_cnt_e55", d_cnt, HALT_EN ? 32'd7 : 32'd50);
        check("sat_cnt", 32'(t_cnt), 32'd15);
        check("sat_timeout", 32'(t_to), 32'd0);
        check("sat_running", 32'(t_run), 32'd1);

        #2;
        rst = 1'b1;
        #1;
        check_def_reset("midrst");
        check("wd_halted_midrst", 32'(w_halt), 32'd0);
        check("wd_timeout_midrst", 32'(w_to), 32'd0);
        check("sat_cnt_midrst", 32'(t_cnt), 32'd0);
        tick();
        tick();
        run_release_seq(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
